// File: rtl/control_state_sequencer.sv
// Sequencer for the multicycle control loop: state register, opcode
// latch, run/halt, memory stalls, traps, retire and cycle counters.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   ns            next-state bits from the control PLA
//   ir_write      IRWrite from the PLA
//   instr_in      instruction word from memory
//   mem_ready     memory access completes this cycle
//   start         pulse: leave halt and begin fetching
//   halt_req      level: stop at the next instruction boundary
//   state         current state to the PLA
//   op            registered opcode to the PLA
//   running       sequencer is advancing
//   illegal       sticky trap flag
//   retire_pulse  one pulse per completed instruction
//   retire_cnt    completed-instruction count
//   cycle_cnt     running-cycle count
module control_state_sequencer #(
  parameter int CNT_W  = 32,
  parameter int OP_LSB = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ns,
  input  logic             ir_write,
  input  logic [31:0]      instr_in,
  input  logic             mem_ready,
  input  logic             start,
  input  logic             halt_req,
  output logic [3:0]       state,
  output logic [5:0]       op,
  output logic             running,
  output logic             illegal,
  output logic             retire_pulse,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_LAST     = 4'd9;

  logic stall;
  logic trap;
  logic retire;
  logic fetch_halt;
  logic op_load;
  logic unused_instr;

  assign unused_instr = ^instr_in;

  always_comb begin
    stall = 1'b0;
    trap = 1'b0;
    retire = 1'b0;
    fetch_halt = 1'b0;
    op_load = 1'b0;
    stall = !mem_ready &&
      (state == S_FETCH ||
       state == S_MEMREAD ||
       state == S_MEMWRITE);
    trap = running && !stall &&
      ((ns > S_LAST) ||
       (state == S_DECODE && ns == S_FETCH));
    retire = running && !stall && !trap &&
      state != S_FETCH && ns == S_FETCH;
    // a halt in FETCH lands before the fetch moves on,
    // so no partially executed instruction is left behind
    fetch_halt = running && !stall && !trap &&
      state == S_FETCH && halt_req;
    op_load = running && state == S_FETCH &&
      ir_write && mem_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      op           <= 6'd0;
      running      <= 1'b0;
      illegal      <= 1'b0;
      retire_pulse <= 1'b0;
      retire_cnt   <= '0;
      cycle_cnt    <= '0;
    end else begin
      retire_pulse <= retire;
      if (op_load)
        op <= instr_in[OP_LSB +: 6];
      if (running)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire)
        retire_cnt <= retire_cnt + CNT_W'(1);
      if (!running) begin
        state <= S_FETCH;
        if (start && !illegal)
          running <= 1'b1;
      end else if (stall) begin
        state <= state;
      end else if (trap) begin
        illegal <= 1'b1;
        running <= 1'b0;
        state   <= S_FETCH;
      end else if (retire) begin
        state <= S_FETCH;
        if (halt_req)
          running <= 1'b0;
      end else if (fetch_halt) begin
        running <= 1'b0;
      end else begin
        state <= ns;
      end
    end
  end

endmodule

// File: tb/tb_control_state_sequencer.sv
// Directed bench for control_state_sequencer with hand-computed
// expectations; narrow counters so wraparound is reachable.
module tb_control_state_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    ns;
  logic          ir_write;
  logic [31:0]   instr_in;
  logic          mem_ready;
  logic          start;
  logic          halt_req;
  logic [3:0]    state;
  logic [5:0]    op;
  logic          running;
  logic          illegal;
  logic          retire_pulse;
  logic [CW-1:0] retire_cnt;
  logic [CW-1:0] cycle_cnt;

  int total = 0;
  int bad = 0;
  logic          m_run;
  logic [CW-1:0] m_cyc;

  control_state_sequencer #(.CNT_W(CW), .OP_LSB(0)) dut (
    .clk(clk), .rst_n(rst_n), .ns(ns), .ir_write(ir_write),
    .instr_in(instr_in), .mem_ready(mem_ready), .start(start),
    .halt_req(halt_req), .state(state), .op(op),
    .running(running), .illegal(illegal),
    .retire_pulse(retire_pulse), .retire_cnt(retire_cnt),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    if (m_run) m_cyc = m_cyc + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_op"}, 32'(op), 0);
    chk({tag, "_run"}, 32'(running), 0);
    chk({tag, "_ill"}, 32'(illegal), 0);
    chk({tag, "_pulse"}, 32'(retire_pulse), 0);
    chk({tag, "_ret"}, 32'(retire_cnt), 0);
    chk({tag, "_cyc"}, 32'(cycle_cnt), 0);
  endtask

  // reset asserted mid-cycle, checked before any clock edge
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 chk_reset(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_run = 1'b0;
    m_cyc = '0;
  endtask

  initial begin
    rst_n = 1'b0; ns = 4'd0; ir_write = 1'b0;
    instr_in = 32'd0; mem_ready = 1'b1;
    start = 1'b0; halt_req = 1'b0;
    m_run = 1'b0; m_cyc = '0;
    #3 chk_reset("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // basic instruction 0,1,2,3,4,0
    start = 1'b1; ns = 4'd1;
    tick(); m_run = 1'b1;
    start = 1'b0;
    chk("start_run", 32'(running), 1);
    chk("start_state", 32'(state), 0);
    ns = 4'd1; tick(); chk("s1", 32'(state), 1);
    ns = 4'd2; tick(); chk("s2", 32'(state), 2);
    ns = 4'd3; tick(); chk("s3", 32'(state), 3);
    ns = 4'd4; tick(); chk("s4", 32'(state), 4);
    ns = 4'd0; tick(); chk("s0", 32'(state), 0);
    chk("ret1", 32'(retire_cnt), 1);
    chk("pulse1", 32'(retire_pulse), 1);
    chk("cyc1", 32'(cycle_cnt), 32'(m_cyc));
    ns = 4'd2; tick();
    chk("pulse1_off", 32'(retire_pulse), 0);
    chk("st2", 32'(state), 2);

    // memory stall in MEMREAD
    ns = 4'd3; tick(); chk("st3", 32'(state), 3);
    mem_ready = 1'b0; ns = 4'd4;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stall_st", 32'(state), 3);
    end
    chk("stall_cyc", 32'(cycle_cnt), 32'(m_cyc));
    chk("stall_ret", 32'(retire_cnt), 1);
    mem_ready = 1'b1;
    tick(); chk("unstall", 32'(state), 4);
    ns = 4'd0; tick(); chk("ret2", 32'(retire_cnt), 2);

    // opcode latch in FETCH, blocked by stall
    ir_write = 1'b1; instr_in = 32'h0000_0033;
    mem_ready = 1'b0; ns = 4'd1;
    tick();
    chk("op_stall", 32'(op), 0);
    chk("op_stall_st", 32'(state), 0);
    mem_ready = 1'b1;
    tick();
    chk("op_load", 32'(op), 32'h33);
    chk("op_st", 32'(state), 1);
    ir_write = 1'b0; instr_in = 32'h0000_0003;
    ns = 4'd6; tick(); chk("exec", 32'(state), 6);
    chk("op_hold", 32'(op), 32'h33);

    // halt at boundary, then restart
    halt_req = 1'b1; ns = 4'd7;
    tick(); chk("h_s7", 32'(state), 7);
    chk("h_run", 32'(running), 1);
    ns = 4'd0; tick(); m_run = 1'b0;
    chk("h_ret", 32'(retire_cnt), 3);
    chk("h_pulse", 32'(retire_pulse), 1);
    chk("h_stop", 32'(running), 0);
    chk("h_st", 32'(state), 0);
    halt_req = 1'b0; ns = 4'd6;
    tick(); tick();
    chk("h_idle_st", 32'(state), 0);
    chk("h_idle_cyc", 32'(cycle_cnt), 32'(m_cyc));
    start = 1'b1; tick(); m_run = 1'b1;
    start = 1'b0;
    chk("resume", 32'(running), 1);

    // retire counter wrap
    for (int i = 0; i < 12; i++) begin
      ns = 4'd6; tick();
      ns = 4'd0; tick();
    end
    chk("ret_ones", 32'(retire_cnt), 32'hF);
    ns = 4'd6; tick();
    ns = 4'd0; tick();
    chk("ret_wrap", 32'(retire_cnt), 0);
    chk("wrap_pulse", 32'(retire_pulse), 1);
    chk("cyc_wrap", 32'(cycle_cnt), 32'(m_cyc));

    // halt in FETCH waits for mem_ready
    halt_req = 1'b1; mem_ready = 1'b0; ns = 4'd1;
    tick(); chk("fh_stall", 32'(running), 1);
    mem_ready = 1'b1;
    tick(); m_run = 1'b0;
    chk("fh_stop", 32'(running), 0);
    chk("fh_st", 32'(state), 0);

    // start and halt_req together: start wins
    start = 1'b1;
    tick(); m_run = 1'b1;
    start = 1'b0; halt_req = 1'b0;
    chk("sh_run", 32'(running), 1);

    // illegal state trap, start ignored
    ns = 4'd6; tick();
    halt_req = 1'b1;
    ns = 4'hA; tick(); m_run = 1'b0;
    halt_req = 1'b0;
    chk("ts_ill", 32'(illegal), 1);
    chk("ts_run", 32'(running), 0);
    chk("ts_st", 32'(state), 0);
    chk("ts_ret", 32'(retire_cnt), 0);
    chk("ts_pulse", 32'(retire_pulse), 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("ts_ign", 32'(running), 0);
    chk("ts_cyc", 32'(cycle_cnt), 32'(m_cyc));
    mid_reset("rst1");

    // illegal opcode trap
    start = 1'b1; tick(); m_run = 1'b1;
    start = 1'b0;
    ns = 4'd1; tick();
    ns = 4'd0; tick(); m_run = 1'b0;
    chk("to_ill", 32'(illegal), 1);
    chk("to_run", 32'(running), 0);
    chk("to_ret", 32'(retire_cnt), 0);
    mid_reset("rst2");

    // reset mid-instruction
    start = 1'b1; tick(); m_run = 1'b1;
    start = 1'b0;
    ir_write = 1'b1; instr_in = 32'h0000_0023;
    ns = 4'd1; tick();
    ir_write = 1'b0;
    chk("mi_op", 32'(op), 32'h23);
    ns = 4'd2; tick();
    chk("mi_st", 32'(state), 2);
    mid_reset("rst3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
